// File: rtl/pipe_scoreboard_fwd_if.sv
// Decode-stage query/issue bundle between the ID stage and the hazard scoreboard.
// master = ID stage (drives issue and operand queries), slave = scoreboard.
interface pipe_scoreboard_fwd_if #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W    = $clog2(DEPTH + 1);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                forward_EN;
  logic                issue_valid;
  logic                issue_wb_en;
  logic                issue_is_load;
  logic [ADDR_W-1:0]   issue_dest;
  logic                flush;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src2;
  logic                use1;
  logic                use2;
  logic                stall;
  logic [SEL_W-1:0]    fwd_sel1;
  logic [SEL_W-1:0]    fwd_sel2;
  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    stall_cycles;
  logic [CNT_W-1:0]    fwd_cycles;

  modport master (
    output forward_EN, issue_valid, issue_wb_en, issue_is_load, issue_dest, flush,
           src1, src2, use1, use2,
    input  stall, fwd_sel1, fwd_sel2, pending, stall_cycles, fwd_cycles
  );

  modport slave (
    input  forward_EN, issue_valid, issue_wb_en, issue_is_load, issue_dest, flush,
           src1, src2, use1, use2,
    output stall, fwd_sel1, fwd_sel2, pending, stall_cycles, fwd_cycles
  );
endinterface

// File: rtl/pipe_scoreboard_fwd.sv
// Shift scoreboard of in-flight register writes; answers ID operand queries with zero latency.
// stall is the only backpressure: it freezes IF/ID and injects a bubble into stage 1.
module pipe_scoreboard_fwd #(
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_scoreboard_fwd_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             hazard;
    logic [SEL_W-1:0] sel;
  } query_t;

  logic [DEPTH:1]      v;
  logic [DEPTH:1]      ld;
  logic [ADDR_W-1:0]   dest [1:DEPTH];
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    fwd_cnt;
  query_t              q1;
  query_t              q2;
  logic                stall;
  logic                push;
  logic [SEL_W-1:0]    sel1;
  logic [SEL_W-1:0]    sel2;
  logic [NUM_REGS-1:0] pend;

  // Scan oldest to youngest so the youngest producer overwrites the match.
  function automatic query_t lookup(input logic [ADDR_W-1:0] src,
                                    input logic              use_i,
                                    input logic              fwd_en);
    query_t r;
    logic   hit;
    logic   m_ld;
    int     m;
    r    = '0;
    hit  = 1'b0;
    m_ld = 1'b0;
    m    = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v[k] && dest[k] == src) begin
        hit  = 1'b1;
        m    = k;
        m_ld = ld[k];
      end
    end
    if (use_i && !(ZERO_REG != 0 && src == '0) && hit) begin
      if (fwd_en && m >= (m_ld ? LOAD_READY : ALU_READY)) r.sel = SEL_W'(m);
      else r.hazard = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    q1    = lookup(bus.src1, bus.use1, bus.forward_EN);
    q2    = lookup(bus.src2, bus.use2, bus.forward_EN);
    stall = bus.issue_valid & ~bus.flush & (q1.hazard | q2.hazard);
    sel1  = stall ? '0 : q1.sel;
    sel2  = stall ? '0 : q2.sel;
    push  = bus.issue_valid & bus.issue_wb_en & ~stall & ~bus.flush &
            ~(ZERO_REG != 0 && bus.issue_dest == '0);
  end

  always_comb begin
    pend = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (v[k]) pend[dest[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v         <= '0;
      ld        <= '0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
      for (int k = 1; k <= DEPTH; k++) dest[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        v[k]    <= v[k-1];
        ld[k]   <= ld[k-1];
        dest[k] <= dest[k-1];
      end
      v[1]    <= push;
      ld[1]   <= bus.issue_is_load;
      dest[1] <= bus.issue_dest;
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!stall && (sel1 != '0 || sel2 != '0) && fwd_cnt != {CNT_W{1'b1}})
        fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.fwd_sel1     = sel1;
  assign bus.fwd_sel2     = sel2;
  assign bus.pending      = pend;
  assign bus.stall_cycles = stall_cnt;
  assign bus.fwd_cycles   = fwd_cnt;
endmodule

// File: tb/tb_pipe_scoreboard_fwd.sv
// Bench for pipe_scoreboard_fwd: per-cycle expectations queued at drive time, popped at sample time.
module tb_pipe_scoreboard_fwd;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 16;

  typedef struct {
    int stall;
    int sel1;
    int sel2;
    int pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_scoreboard_fwd_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) sb_if ();

  pipe_scoreboard_fwd #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ALU_READY(1), .LOAD_READY(2),
    .ZERO_REG(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sb_if.slave)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    sb_if.forward_EN    = 1'b1;
    sb_if.issue_valid   = 1'b0;
    sb_if.issue_wb_en   = 1'b0;
    sb_if.issue_is_load = 1'b0;
    sb_if.issue_dest    = '0;
    sb_if.flush         = 1'b0;
    sb_if.src1          = '0;
    sb_if.src2          = '0;
    sb_if.use1          = 1'b0;
    sb_if.use2          = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst = 1'b0;
    @(negedge clk);
    check({tag, ".stall"},   int'(sb_if.stall), 0);
    check({tag, ".pending"}, int'(sb_if.pending), 0);
    check({tag, ".scnt"},    int'(sb_if.stall_cycles), 0);
    check({tag, ".fcnt"},    int'(sb_if.fwd_cycles), 0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives one ID cycle; e_pend < 0 skips the pending comparison.
  task automatic step(input string tag, input logic fe, input logic iv, input logic wb,
                      input logic ld, input int dest, input logic fl,
                      input int s1, input logic u1, input int s2, input logic u2,
                      input int e_st, input int e_s1, input int e_s2, input int e_pend);
    exp_t e;
    sb_if.forward_EN    = fe;
    sb_if.issue_valid   = iv;
    sb_if.issue_wb_en   = wb;
    sb_if.issue_is_load = ld;
    sb_if.issue_dest    = ADDR_W'(dest);
    sb_if.flush         = fl;
    sb_if.src1          = ADDR_W'(s1);
    sb_if.use1          = u1;
    sb_if.src2          = ADDR_W'(s2);
    sb_if.use2          = u2;
    e.stall = e_st;
    e.sel1  = e_s1;
    e.sel2  = e_s2;
    e.pend  = e_pend;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".stall"}, int'(sb_if.stall), e.stall);
      check({tag, ".sel1"},  int'(sb_if.fwd_sel1), e.sel1);
      check({tag, ".sel2"},  int'(sb_if.fwd_sel2), e.sel2);
      if (e.pend >= 0) check({tag, ".pending"}, int'(sb_if.pending), e.pend);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    do_reset("rst0");

    // ALU producer forwarded from stages 1, 2, 3, then read from the file.
    step("alu_issue", 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu_s1",    1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 'h8);
    step("alu_s2",    1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 2, 0, 'h8);
    step("alu_s3",    1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 3, 0, 'h8);
    step("alu_rf",    1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    check("alu.fcnt", int'(sb_if.fwd_cycles), 3);
    check("alu.scnt", int'(sb_if.stall_cycles), 0);

    // Load-use: one stall cycle then forward from stage 2.
    do_reset("rst1");
    step("ld_issue", 1, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ld_use",   1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 'h20);
    step("ld_fwd",   1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 2, 'h20);
    check("ld.scnt", int'(sb_if.stall_cycles), 1);
    check("ld.fcnt", int'(sb_if.fwd_cycles), 1);

    // Forwarding disabled: stall until the producer retires.
    do_reset("rst2");
    step("nf_issue",  0, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("nf_stall1", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 'h80);
    step("nf_stall2", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 'h80);
    step("nf_stall3", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 'h80);
    step("nf_rf",     0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    check("nf.scnt", int'(sb_if.stall_cycles), 3);
    check("nf.fcnt", int'(sb_if.fwd_cycles), 0);

    // Younger load shadows an older ALU write to the same register.
    do_reset("rst3");
    step("sh_alu",   1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sh_ld",    1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 'h4);
    step("sh_stall", 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 'h4);
    step("sh_fwd",   1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 2, 0, 'h4);

    // r0 never tracked; unused operands never match.
    do_reset("rst4");
    step("z_add_r0",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("z_read_r0", 1, 1, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("z_unused",  1, 1, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 'h10);
    step("z_used",    1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 2, 0, 'h10);

    // Flush beats a hazard and inserts a bubble; reset clears a live stall.
    do_reset("rst5");
    step("fl_ld",     1, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("fl_flush",  1, 1, 1, 0, 9, 1, 6, 1, 0, 0, 0, 0, 0, 'h40);
    step("fl_ld8",    1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 'h40);
    step("rs_stall1", 0, 1, 0, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 'h140);
    check("rs.scnt_pre", int'(sb_if.stall_cycles), 1);
    @(negedge clk);
    check("rs.stall_pre", int'(sb_if.stall), 1);
    #2 rst = 1'b0;
    #1;
    check("rs.stall",   int'(sb_if.stall), 0);
    check("rs.pending", int'(sb_if.pending), 0);
    check("rs.scnt",    int'(sb_if.stall_cycles), 0);
    check("rs.fcnt",    int'(sb_if.fwd_cycles), 0);

    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
